// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the 8-bit RISC datapath.
// The sequencer (master) receives the opcode and memory handshake and drives
// every datapath control line; the datapath side uses the slave modport.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, mem_err, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, mem_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 8-bit RISC datapath.
// Steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, with a bounded wait on every
// memory access (MEM_TIMEOUT cycles, then mem_err and a return to FETCH).
// Build option: define MC_JUMP_EN to generate the JUMP state for opcode 000010;
// without it that opcode is reported as illegal.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8
`ifdef MC_JUMP_EN
    , S_JUMP    = 4'd9
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  // Last wait count at which a still-low mem_ready gives up.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] wait_cnt_r;
  logic       is_store_r;
  logic       wait_state_s;
  logic       timeout_s;

  assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                        (state_r == S_MEM_WRITE);
  // A ready on the final allowed cycle still completes the access.
  assign timeout_s    = wait_state_s && !bus.mem_ready && (wait_cnt_r == WAIT_LAST);
  assign bus.state    = state_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory wait counter: restarts on every state entry (including a FETCH retry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_next_s != state_r) || timeout_s) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_state_s && !bus.mem_ready) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Load/store class captured in DECODE so MEM_ADDR no longer depends on op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      is_store_r <= (bus.op == OP_SW);
    end else begin
      is_store_r <= is_store_r;
    end
  end

  // Next-state and control decode; every output defaults to 0.
  always_comb begin
    state_next_s      = state_r;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.mem_err       = 1'b0;

    case (state_r)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_next_s = S_DECODE;
        end else if (timeout_s) begin
          bus.mem_err  = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op)
          OP_RTYPE:     state_next_s = S_R_EXEC;
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_BEQ:       state_next_s = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_J:         state_next_s = S_JUMP;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
            state_next_s   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (is_store_r) begin
          state_next_s = S_MEM_WRITE;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_next_s = S_MEM_WB;
        end else if (timeout_s) begin
          bus.mem_err  = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_next_s   = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_next_s   = S_FETCH;
        end else if (timeout_s) begin
          bus.mem_err  = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_next_s  = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_next_s   = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        state_next_s      = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        state_next_s   = S_FETCH;
      end
`endif
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (built with MEM_TIMEOUT = 4).
// Each cycle the whole control word and the state code are compared against
// hand-derived per-state values. Inputs change 1 time unit after the rising
// edge; outputs are sampled 3 units later, well before the falling edge.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Field order: pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  // instr_done, illegal_op, mem_err
  wire [18:0] outs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                      bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                      bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.instr_done, bus.illegal_op, bus.mem_err};

  localparam logic [18:0] O_FETCH_WAIT = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_FETCH_RDY  = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_FETCH_TO   = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b1};
  localparam logic [18:0] O_DECODE     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_DECODE_ILL = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1,1'b1,1'b0};
  localparam logic [18:0] O_MEM_ADDR   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_MEM_READ   = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_MEM_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] O_MW_WAIT    = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_MW_RDY     = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] O_MW_TO      = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1};
  localparam logic [18:0] O_R_EXEC     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0};
  localparam logic [18:0] O_R_WB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] O_BRANCH     = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1,1'b0,1'b0};
`ifdef MC_JUMP_EN
  localparam logic [18:0] O_JUMP       = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0};
`endif

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.op        = 6'b000000;
    bus.mem_ready = 1'b0;
    #2;
    n_checks++;
    if ({bus.state, outs} !== {4'd0, O_FETCH_WAIT}) begin
      n_fail++;
      $display("FAIL reset_async: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs, O_FETCH_WAIT);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({bus.state, outs} !== {4'd0, O_FETCH_WAIT}) begin
      n_fail++;
      $display("FAIL reset_held: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs, O_FETCH_WAIT);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [0:3];
    logic [18:0] ex [0:3];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    ex = '{O_FETCH_RDY, O_DECODE, O_R_EXEC, O_R_WB};
    bus.op = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL rtype cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [0:7];
    logic [18:0] ex [0:7];
    logic        rd [0:7];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    ex = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MEM_READ, O_MEM_READ, O_MEM_READ, O_MEM_READ, O_MEM_WB};
    // Ready arrives on the 4th MEM_READ cycle: exactly the timeout cycle, so it must succeed.
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rd[i];
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [0:2];
    logic [18:0] ex [0:2];
    st = '{4'd0, 4'd1, 4'd0};
    ex = '{O_FETCH_RDY, O_DECODE_ILL, O_FETCH_WAIT};
    bus.op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i < 2);
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    // Finish the pending fetch so the next test starts from a fresh FETCH.
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    logic [3:0]  st [0:2];
    logic [18:0] ex [0:2];
    st = '{4'd0, 4'd1, 4'd8};
    ex = '{O_FETCH_RDY, O_DECODE, O_BRANCH};
    bus.op = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL branch cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    logic [3:0]  st [0:2];
    logic [18:0] ex [0:2];
    int          n;
`ifdef MC_JUMP_EN
    st = '{4'd0, 4'd1, 4'd9};
    ex = '{O_FETCH_RDY, O_DECODE, O_JUMP};
    n  = 3;
`else
    st = '{4'd0, 4'd1, 4'd0};
    ex = '{O_FETCH_RDY, O_DECODE_ILL, O_FETCH_RDY};
    n  = 2;
`endif
    bus.op = 6'b000010;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'b1;
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL jump cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [3:0]  st [0:10];
    logic [18:0] ex [0:10];
    logic        rd [0:10];
    // Four low cycles time out; the retry's counter restarts, so three more low cycles are tolerated.
    st = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
    ex = '{O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_TO, O_FETCH_WAIT, O_FETCH_WAIT,
           O_FETCH_WAIT, O_FETCH_RDY, O_DECODE, O_R_EXEC, O_R_WB};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.op = 6'b000000;
    for (int i = 0; i < 11; i++) begin
      bus.mem_ready = rd[i];
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL fetch_timeout cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    logic [3:0]  st [0:10];
    logic [18:0] ex [0:10];
    logic        rd [0:10];
    // Timed-out store, then the refetched store completes in the 4-cycle minimum.
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd5};
    ex = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MW_WAIT, O_MW_WAIT, O_MW_WAIT, O_MW_TO,
           O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MW_RDY};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.op = 6'b101011;
    for (int i = 0; i < 11; i++) begin
      bus.mem_ready = rd[i];
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL sw_timeout cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  st [0:3];
    logic [18:0] ex [0:3];
    logic        rd [0:3];
    st = '{4'd0, 4'd1, 4'd2, 4'd5};
    ex = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MW_WAIT};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rd[i];
      #3;
      n_checks++;
      if ({bus.state, outs} !== {st[i], ex[i]}) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs, st[i], ex[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // Drop reset between edges: must act before the next clock.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, outs} !== {4'd0, O_FETCH_WAIT}) begin
      n_fail++;
      $display("FAIL reset_mid_async: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs, O_FETCH_WAIT);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.state, outs} !== {4'd0, O_FETCH_WAIT}) begin
      n_fail++;
      $display("FAIL reset_mid_held: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs, O_FETCH_WAIT);
    end
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #3;
    n_checks++;
    if ({bus.state, outs} !== {4'd0, O_FETCH_RDY}) begin
      n_fail++;
      $display("FAIL reset_mid_resume: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs, O_FETCH_RDY);
    end
  endtask

  // Test sequence and summary.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_illegal();
    test_branch();
    test_jump();
    test_fetch_timeout();
    test_sw_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 8-bit RISC datapath. It decodes the opcode held in the instruction register and steps the shared ALU, memory port, register file and PC through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake with a bounded wait. `alu_op` uses the same 2-bit encoding that `alu_control` already consumes.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles spent waiting for `mem_ready` in any memory state; legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode field of the instruction register; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by ALU zero (branch).
- `pc_source`  out  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target.
- `i_or_d`  out  1  memory address select: 0 PC, 1 ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  writeback source: 1 MDR, 0 ALUOut.
- `reg_dst`  out  1  destination select: 1 rd, 0 rt.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A select: 0 PC, 1 rs.
- `alu_src_b`  out  2  ALU B select: 00 rt, 01 constant 1, 10 sign-extended imm, 11 branch offset.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 use funct field.
- `instr_done`  out  1  one-cycle pulse on the last cycle of every retired instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE when `op` is unsupported.
- `mem_err`  out  1  one-cycle pulse when a memory wait times out.
- `state`  out  4  current state code, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9.
- FETCH
  - `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write`, `pc_write` and `pc_source`=00 are asserted only when `mem_ready`=1 (Mealy); the state then advances to DECODE.
- DECODE
  - `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precompute branch target).
  - Next state from `op`: 000000 to R_EXEC; 100011 and 101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP (only with `MC_JUMP_EN`).
  - Any other opcode: `illegal_op`=1 and `instr_done`=1, next state FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state MEM_READ for lw, MEM_WRITE for sw; the opcode class is latched in DECODE.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1, next state FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. On `mem_ready`: `instr_done`=1, next state FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1, next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1, next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1, next state FETCH.
- Any output not listed for a state is 0 in that state.
- Wait counter:
  - Cleared on entry to each memory-wait state; increments every cycle that `mem_ready`=0.
  - When the count reaches `MEM_TIMEOUT` with `mem_ready` still 0, `mem_err` pulses and the state returns to FETCH.
  - On a FETCH timeout, `pc_write` and `ir_write` stay 0, so the same address is refetched. A timed-out load or store asserts no `reg_write` and no `instr_done`.
  - `mem_ready`=1 on the timeout cycle counts as success; the access wins.

## Timing
- Reset (asynchronous, `rst_n`=0): state FETCH, wait counter 0, latched class cleared. All outputs 0 except FETCH's `mem_read`=1, `alu_src_b`=01.
- Reset asserted mid-instruction aborts it immediately. No partial `reg_write` or `mem_write` occurs after reset asserts.
- Minimum latency with zero wait: lw 5, sw 4, R-type 4, beq 3, j 3 cycles. Each cycle `mem_ready` is held low adds exactly 1 cycle.
- All state changes happen on the rising edge of `clk`. Outputs are combinational from the state, plus `mem_ready` where noted.
- `mem_read` and `mem_write` are never high in the same cycle.

## Configuration
- `MC_JUMP_EN` defined: opcode 000010 enters JUMP; 10 states are used.
- `MC_JUMP_EN` undefined: the JUMP state is not generated, opcode 000010 is treated as illegal, and `pc_source` never drives 10.

## Test plan
- Reset, then R-type (`op`=000000), `mem_ready`=1 throughout -> states 0,1,6,7,0. `reg_write`=1 with `reg_dst`=1 only in state 7; `instr_done` pulses once.
- lw (`op`=100011), `mem_ready` low for 3 cycles in MEM_READ -> 8-cycle instruction. `reg_write`=1 with `mem_to_reg`=1 in state 4.
- sw with `MEM_TIMEOUT`=4 and `mem_ready` held 0 -> `mem_err` pulses after 4 wait cycles, returns to FETCH, `mem_write` drops, no `instr_done`.
- `op`=111111 -> `illegal_op`=1 and `instr_done`=1 in DECODE, FETCH next cycle, no `reg_write` or `mem_write`.
- beq -> state 8 with `pc_write_cond`=1, `alu_op`=01. `op`=000010 -> JUMP with `pc_source`=10 when `MC_JUMP_EN` is defined; `illegal_op` when it is not.
- Drop `rst_n` in MEM_WRITE while `mem_ready`=0 -> `state`=0 and `mem_write`=0 asynchronously, before the next clock edge.
